// File: rtl/seven_seg_scan_controller_if.sv
// Host-side bus of the seven-segment scan controller: value load strobe,
// digit data, leading-zero mode and the pending status flag.
interface seven_seg_scan_controller_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    lz_suppress;
  logic                    pending;

  modport master (output load, output value, output lz_suppress, input pending);
  modport slave  (input load, input value, input lz_suppress, output pending);
endinterface

// File: rtl/seven_seg_scan_controller.sv
// Time-multiplexed common-anode display scanner sharing one 7-seg decoder.
// Each digit slot starts with all anodes off while the decoder settles on
// the new nibble; new values are double-buffered and swapped only at the
// end of the last digit's slot so a frame never mixes old and new digits.
module seven_seg_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  seven_seg_scan_controller_if.slave  host,
  output logic [3:0]                  digit_nibble_o,
  output logic [NUM_DIGITS-1:0]       anode_n_o,
  output logic                        frame_start_o
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         shadow_q, disp_q;
  logic                  pending_q, lz_q;
  logic [3:0]            nibble_q;
  logic [NUM_DIGITS-1:0] anode_q;
  logic                  fs_q;

  logic                  slot_end, frame_end;
  logic [3:0]            sel_nibble;
  logic                  upper_zero, upper_zero_i;
  logic [NUM_DIGITS-1:0] anode_sel;

  assign slot_end  = (cnt_q == CW'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (idx_q == IW'(NUM_DIGITS - 1));
  assign anode_sel = ~(NUM_DIGITS'(1) << idx_q);

  // Slot counter and digit index next-state.
  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end)
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
  end

  // Nibble for the current digit; leading zeros (never digit 0) map to blank.
  always_comb begin
    sel_nibble   = 4'hF;
    upper_zero   = 1'b1;
    upper_zero_i = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero_i = upper_zero && (disp_q[4*i +: 4] == 4'h0);
      if (IW'(i) == idx_q)
        sel_nibble = (lz_q && (i != 0) && upper_zero_i) ? 4'hF : disp_q[4*i +: 4];
      upper_zero = upper_zero_i;
    end
  end

  // Scan FSM: counters, blank/show state and the registered pin outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= BLANK;
      cnt_q    <= '0;
      idx_q    <= '0;
      nibble_q <= 4'hF;
      anode_q  <= '1;
      fs_q     <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      fs_q  <= (cnt_q == '0) && (idx_q == '0);
      if (cnt_q == '0)
        nibble_q <= sel_nibble;
      case (state_q)
        BLANK: begin
          anode_q <= '1;
          if (cnt_q == CW'(BLANK_CYCLES - 1))
            state_q <= SHOW;
        end
        SHOW: begin
          anode_q <= anode_sel;
          if (slot_end)
            state_q <= BLANK;
        end
        default: state_q <= BLANK;
      endcase
    end
  end

  // Shadow/display double buffer; swap and lz sampling only at frame end.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      lz_q      <= 1'b0;
    end else if (frame_end) begin
      lz_q <= host.lz_suppress;
      if (host.load) begin
        disp_q    <= host.value;
        pending_q <= 1'b0;
      end else if (pending_q) begin
        disp_q    <= shadow_q;
        pending_q <= 1'b0;
      end
    end else if (host.load) begin
      shadow_q  <= host.value;
      pending_q <= 1'b1;
    end
  end

  assign host.pending   = pending_q;
  assign digit_nibble_o = nibble_q;
  assign anode_n_o      = anode_q;
  assign frame_start_o  = fs_q;
endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Randomized bench for seven_seg_scan_controller against a frame-level model
// that derives slot position from the count of clock edges since reset.
module tb_seven_seg_scan_controller;
  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FR = N * RD;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] nib;
  logic [3:0] an;
  logic       fs;

  always #5 clk = ~clk;

  seven_seg_scan_controller_if #(.NUM_DIGITS(N)) bus ();

  seven_seg_scan_controller #(
    .NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .host           (bus),
    .digit_nibble_o (nib),
    .anode_n_o      (an),
    .frame_start_o  (fs)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int          k;
  logic [15:0] m_disp, m_shadow;
  bit          m_pend, m_lz;
  logic [3:0]  e_nib, e_an;
  bit          e_fs;
  bit          cur_lz = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, act, exp, k);
    end
  endtask

  function automatic logic [3:0] lz_nib(input int i, input logic [15:0] d, input bit lz);
    logic [15:0] up;
    up = d >> (4 * i);
    if (lz && i > 0 && up == 16'h0) return 4'hF;
    return up[3:0];
  endfunction

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic step(input bit r, input bit ld, input logic [15:0] v);
    int slot, idx;
    logic [3:0] oh;
    rst             = r;
    bus.load        = ld;
    bus.value       = v;
    bus.lz_suppress = cur_lz;
    @(posedge clk);
    if (r) begin
      k = 0; m_disp = '0; m_shadow = '0; m_pend = 0; m_lz = 0;
      e_an = 4'hF; e_nib = 4'hF; e_fs = 0;
    end else begin
      slot = k % RD;
      idx  = (k / RD) % N;
      e_fs = (k % FR == 0);
      if (slot == 0) e_nib = lz_nib(idx, m_disp, m_lz);
      oh   = 4'b1 << idx;
      e_an = (slot >= BC) ? ~oh : 4'hF;
      if (k % FR == FR - 1) begin
        if (ld) begin m_disp = v; m_pend = 0; end
        else if (m_pend) begin m_disp = m_shadow; m_pend = 0; end
        m_lz = cur_lz;
      end else if (ld) begin
        m_shadow = v; m_pend = 1;
      end
      k++;
    end
    @(negedge clk);
    chk("anode_n", an, e_an);
    chk("digit_nibble", nib, e_nib);
    chk("frame_start", fs, e_fs);
    chk("pending", bus.pending, m_pend);
    chk("anode_onehot", ($countones(~an) <= 1), 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0);
  endtask

  // advance (at most one frame) until the next edge sees frame position m
  task automatic idle_until(input int m);
    for (int i = 0; i < FR && (k % FR) != m; i++) step(0, 0, 16'h0);
  endtask

  initial begin
    rst = 1'b1; bus.load = 1'b0; bus.value = '0; bus.lz_suppress = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1, 0, 16'h0);
    // free-running scan
    idle(64);
    // mid-frame load
    idle_until(10);
    step(0, 1, 16'h1234);
    idle(2 * FR);
    // leading zero suppression
    cur_lz = 1'b1;
    idle_until(3);
    step(0, 1, 16'h0050);
    idle(2 * FR);
    step(0, 1, 16'h0000);
    idle(2 * FR);
    cur_lz = 1'b0;
    // two loads in one frame, then a load on the boundary cycle
    idle_until(5);
    step(0, 1, 16'hAAAA);
    idle_until(12);
    step(0, 1, 16'hBBBB);
    idle(FR + 8);
    idle_until(FR - 1);
    step(0, 1, 16'hCDE0);
    idle(FR + 4);
    // reset during digit 2 show phase, with a load pending
    idle_until(2 * RD + 1);
    step(0, 1, 16'h4321);
    idle_until(2 * RD + 4);
    step(1, 0, 16'h0);
    idle(64);
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) cur_lz = ~cur_lz;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0,
           16'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
